// File: rtl/bit_reverse_echo.sv
// bit_reverse_echo: collects ASCII '0'/'1' characters into a word, then
// echoes the word back, reversed or in order, followed by an optional CR/LF.
module bit_reverse_echo #(
  parameter int WIDTH = 8,
  parameter int CRLF  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             err,
  output logic             drop
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    COLLECT,
    SEND,
    CR,
    LF
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] rev;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic             is_bit;
  logic             done;
  logic             fire;
  logic [7:0]       tx_char;

  assign is_bit = new_rx_data &&
                  (rx_data == 8'h30 || rx_data == 8'h31);
  assign done   = (count == CW'(WIDTH));
  // never strobe on back-to-back cycles
  assign fire   = (state != COLLECT) && !tx_busy && !new_tx_data;

  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = shreg[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_char   = 8'h00;
    unique case (state)
      COLLECT: begin
        if (done) state_nxt = SEND;
      end
      SEND: begin
        tx_char = word[idx] ? 8'h31 : 8'h30;
        if (fire && idx == '0) begin
          state_nxt = (CRLF != 0) ? CR : COLLECT;
        end
      end
      CR: begin
        tx_char = 8'h0D;
        if (fire) state_nxt = LF;
      end
      LF: begin
        tx_char = 8'h0A;
        if (fire) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      shreg       <= '0;
      word        <= '0;
      idx         <= '0;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      word_valid  <= 1'b0;
      err         <= 1'b0;
      drop        <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      word_valid  <= 1'b0;
      err         <= 1'b0;
      drop        <= 1'b0;
      if (state == COLLECT && !done) begin
        if (is_bit) begin
          shreg <= {shreg[WIDTH-2:0], rx_data[0]};
          count <= count + 1'b1;
        end else if (new_rx_data) begin
          err <= 1'b1;
        end
      end else if (new_rx_data) begin
        drop <= 1'b1;
      end
      // completion is a cycle of its own, so no bit can race it
      if (state == COLLECT && done) begin
        word       <= mode ? shreg : rev;
        word_valid <= 1'b1;
        count      <= '0;
        shreg      <= '0;
        idx        <= IW'(WIDTH - 1);
      end
      if (fire) begin
        tx_data     <= tx_char;
        new_tx_data <= 1'b1;
        if (state == SEND) idx <= idx - 1'b1;
      end
    end
  end

endmodule
